// File: rtl/sccb_pkg.sv
// Shared SCCB/I2C target definitions: FSM state codes, R/W and ACK bit values,
// and the open-drain drive helper.
package sccb_pkg;

    typedef logic [3:0] sccb_state_t;

    localparam sccb_state_t ST_IDLE      = 4'd0;
    localparam sccb_state_t ST_DEV_ADDR  = 4'd1;
    localparam sccb_state_t ST_ACK_DEV   = 4'd2;
    localparam sccb_state_t ST_SUB_ADDR  = 4'd3;
    localparam sccb_state_t ST_ACK_SUB   = 4'd4;
    localparam sccb_state_t ST_WR_DATA   = 4'd5;
    localparam sccb_state_t ST_ACK_WR    = 4'd6;
    localparam sccb_state_t ST_RD_DATA   = 4'd7;
    localparam sccb_state_t ST_RD_ACK    = 4'd8;
    localparam sccb_state_t ST_WAIT_STOP = 4'd9;

    localparam logic SCCB_WR_BIT = 1'b0;
    localparam logic SCCB_RD_BIT = 1'b1;
    localparam logic SCCB_ACK    = 1'b0;
    localparam logic SCCB_NACK   = 1'b1;

    // Open-drain: a 0 on the bus means pull low, a 1 means let the pull-up win.
    function automatic logic sda_drive(input logic b);
        return (b == 1'b0);
    endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, plus a history flop
// giving single-cycle rise/fall pulses on the synchronized level.
module sccb_sync_edge (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Bus lines idle high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_lvl  = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target with an internal 8-bit register file. SCL and SDA are
// oversampled on iCLK; SDA is driven open-drain (0 or high-Z only).
module sccb_target_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID  = 7'h21,
    parameter int         REG_AW  = 8,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    input  logic              HOST_WE,
    input  logic [REG_AW-1:0] HOST_ADDR,
    input  logic [7:0]        HOST_WDATA,
    output logic [7:0]        HOST_RDATA,
    output logic              WR_VLD,
    output logic [REG_AW-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              BUSY
);

    localparam int DEPTH = 1 << REG_AW;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic w_last_bit;
    logic w_bus_we;
    logic [7:0] w_byte;
    logic [7:0] w_rd_word;
    logic [7:0] w_rd_next;
    logic [REG_AW-1:0] w_ptr_inc;

    sccb_state_t       r_state;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_rw;
    logic              r_ack_ph;
    logic [REG_AW-1:0] r_ptr;
    logic              r_sda_oe;
    logic              r_busy;
    logic              r_wr_vld;
    logic [REG_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_host_rdata;
    logic [7:0]        r_regs [DEPTH];

    sccb_sync_edge u_scl_sync (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_d    (I2C_SCLK),
        .o_lvl  (w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    sccb_sync_edge u_sda_sync (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_d    (I2C_SDAT),
        .o_lvl  (w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    // Output enable is a flop with async clear, so reset releases SDA immediately.
    assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;

    assign w_start    = w_scl & w_sda_fall;
    assign w_stop     = w_scl & w_sda_rise;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_rd_word  = r_regs[r_ptr];
    assign w_rd_next  = r_regs[w_ptr_inc];
    assign w_bus_we   = (r_state == ST_WR_DATA) && w_scl_rise && w_last_bit
                        && !w_start && !w_stop;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_ack_ph  <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_wr_vld <= 1'b0;
            if (w_start) begin
                r_busy    <= 1'b1;
                r_state   <= ST_DEV_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_ack_ph  <= 1'b0;
            end else if (w_stop) begin
                r_busy   <= 1'b0;
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_ack_ph <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                r_rw      <= w_sda;
                                r_ack_ph  <= 1'b0;
                                r_state   <= (w_byte[7:1] == DEV_ID) ? ST_ACK_DEV : ST_WAIT_STOP;
                            end
                        end
                    end
                    // ACK phases: first SCL fall starts driving, second fall ends the pulse.
                    ST_ACK_DEV: begin
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                r_sda_oe <= sda_drive(SCCB_ACK);
                                r_ack_ph <= 1'b1;
                            end else begin
                                r_ack_ph  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                if (r_rw == SCCB_WR_BIT) begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= ST_SUB_ADDR;
                                end else begin
                                    r_shift  <= w_rd_word;
                                    r_sda_oe <= sda_drive(w_rd_word[7]);
                                    r_state  <= ST_RD_DATA;
                                end
                            end
                        end
                    end
                    ST_SUB_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                r_ptr     <= w_byte[REG_AW-1:0];
                                r_ack_ph  <= 1'b0;
                                r_state   <= ST_ACK_SUB;
                            end
                        end
                    end
                    ST_ACK_SUB, ST_ACK_WR: begin
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                r_sda_oe <= sda_drive(SCCB_ACK);
                                r_ack_ph <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_ack_ph  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_WR_DATA;
                                if (r_state == ST_ACK_WR) begin
                                    r_ptr <= w_ptr_inc;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                r_wr_vld  <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ack_ph  <= 1'b0;
                                r_state   <= ST_ACK_WR;
                            end
                        end
                    end
                    // Bit count tracks master sample edges; after the eighth, release for the master's ACK.
                    ST_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_ack_ph  <= 1'b0;
                                r_state   <= ST_RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= sda_drive(r_shift[6]);
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == SCCB_NACK) begin
                                r_state <= ST_WAIT_STOP;
                            end else begin
                                r_ack_ph <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_ack_ph  <= 1'b0;
                            r_ptr     <= w_ptr_inc;
                            r_shift   <= w_rd_next;
                            r_sda_oe  <= sda_drive(w_rd_next[7]);
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_RD_DATA;
                        end
                    end
                    ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bus write is applied last so it overrides a same-cycle host write to the same address.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            if (HOST_WE) begin
                r_regs[HOST_ADDR] <= HOST_WDATA;
            end
            if (w_bus_we) begin
                r_regs[r_ptr] <= w_byte;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_host_rdata <= 8'h00;
        end else begin
            r_host_rdata <= r_regs[HOST_ADDR];
        end
    end

    assign HOST_RDATA = r_host_rdata;
    assign WR_VLD     = r_wr_vld;
    assign WR_ADDR    = r_wr_addr;
    assign WR_DATA    = r_wr_data;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Bench for sccb_target_regfile: bit-level I2C master BFM, array reference model
// of the register file and pointer, and a WR_VLD scoreboard monitor.
module tb_sccb_target_regfile;

    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_wdata = 8'h00;
    logic [7:0] host_rdata;
    logic       wr_vld;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    sccb_target_regfile dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .I2C_SCLK   (scl),
        .I2C_SDAT   (sda),
        .HOST_WE    (host_we),
        .HOST_ADDR  (host_addr),
        .HOST_WDATA (host_wdata),
        .HOST_RDATA (host_rdata),
        .WR_VLD     (wr_vld),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .BUSY       (busy)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  mem [256];
    logic [7:0]  mptr;
    logic [15:0] exp_q [$];
    logic [7:0]  wr_bytes [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every bus write landing in the register file must match the queue head.
    always @(negedge clk) begin
        if (rst_n && wr_vld) begin
            if (exp_q.size() == 0) begin
                chk("wr_vld_unexpected", {16'h0, wr_addr, wr_data}, 32'h0);
            end else begin
                chk("wr_vld_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bit_xfer(input logic b, output logic s);
        #Q m_low = ~b;
        #Q scl = 1'b1;
        #Q s = sda;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_start();
        #Q m_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        #Q m_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_low = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mem[a] = d;
    endtask

    task automatic host_check(input logic [7:0] a);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        @(negedge clk);
        chk("host_rdata", {24'h0, host_rdata}, {24'h0, mem[a]});
    endtask

    // Write frame {id, sub, wr_bytes...}; only an exact write address to this target is acknowledged.
    task automatic frame_write(input logic [7:0] id, input logic [7:0] sub);
        logic a;
        logic hit;
        hit = (id == 8'h42);
        i2c_start();
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        write_byte(id, a);
        chk("ack_dev", {31'h0, a}, hit ? 32'h0 : 32'h1);
        write_byte(sub, a);
        chk("ack_sub", {31'h0, a}, hit ? 32'h0 : 32'h1);
        if (hit) mptr = sub;
        foreach (wr_bytes[j]) begin
            if (hit) begin
                mem[mptr] = wr_bytes[j];
                exp_q.push_back({mptr, wr_bytes[j]});
                mptr = mptr + 8'd1;
            end
            write_byte(wr_bytes[j], a);
            chk("ack_wr", {31'h0, a}, hit ? 32'h0 : 32'h1);
        end
        i2c_stop();
        chk("busy_after_stop", {31'h0, busy}, 32'h0);
        chk("sda_released", {31'h0, sda}, 32'h1);
    endtask

    // Split or repeated-START read of n bytes starting at sub; last byte is NACKed.
    task automatic frame_read(input logic [7:0] sub, input int n, input logic sr);
        logic a;
        logic [7:0] d;
        logic [7:0] e;
        i2c_start();
        write_byte(8'h42, a);
        chk("rd_ack_dev_w", {31'h0, a}, 32'h0);
        write_byte(sub, a);
        chk("rd_ack_sub", {31'h0, a}, 32'h0);
        mptr = sub;
        if (sr) begin
            i2c_rstart();
        end else begin
            i2c_stop();
            chk("busy_split", {31'h0, busy}, 32'h0);
            i2c_start();
        end
        write_byte(8'h43, a);
        chk("rd_ack_dev_r", {31'h0, a}, 32'h0);
        for (int i = 0; i < n; i++) begin
            e = mem[mptr];
            read_byte((i == n - 1), d);
            chk("rd_data", {24'h0, d}, {24'h0, e});
            if (i != n - 1) mptr = mptr + 8'd1;
        end
        i2c_stop();
        chk("busy_after_rd", {31'h0, busy}, 32'h0);
        chk("sda_released_rd", {31'h0, sda}, 32'h1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mptr = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_wr_vld"}, {31'h0, wr_vld}, 32'h0);
        chk({tag, "_wr_addr"}, {24'h0, wr_addr}, 32'h0);
        chk({tag, "_wr_data"}, {24'h0, wr_data}, 32'h0);
        chk({tag, "_host_rdata"}, {24'h0, host_rdata}, 32'h0);
        chk({tag, "_sda"}, {31'h0, sda}, 32'h1);
    endtask

    initial begin
        logic s;
        logic a;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Basic write and split read of the same byte
        wr_bytes = '{8'h80};
        frame_write(8'h42, 8'h12);
        host_check(8'h12);
        frame_read(8'h12, 1, 1'b0);

        // Foreign address must be ignored
        wr_bytes = '{8'h55};
        frame_write(8'h44, 8'h12);
        host_check(8'h12);

        // Burst across the top of the address space
        wr_bytes = '{8'hA1, 8'hA2, 8'hA3};
        frame_write(8'h42, 8'hFE);
        host_check(8'hFE);
        host_check(8'hFF);
        host_check(8'h00);

        // Repeated START read of two bytes
        wr_bytes = '{8'h11, 8'h22};
        frame_write(8'h42, 8'h30);
        frame_read(8'h30, 2, 1'b1);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] sub;
            logic [7:0] id;
            sub = 8'($urandom_range(0, 255));
            id = ($urandom_range(0, 3) == 0) ? 8'h46 : 8'h42;
            wr_bytes.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) wr_bytes.push_back(8'($urandom_range(0, 255)));
            frame_write(id, sub);
            if ($urandom_range(0, 1) == 1) host_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            frame_read(sub, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            host_check(sub);
            host_check(8'($urandom_range(0, 255)));
        end

        // Reset while the target is pulling SDA low in the middle of a read byte
        host_write(8'h50, 8'h00);
        i2c_start();
        write_byte(8'h42, a);
        write_byte(8'h50, a);
        i2c_rstart();
        write_byte(8'h43, a);
        chk("rst_rd_ack_dev", {31'h0, a}, 32'h0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
        #Q m_low = 1'b0;
        #Q scl = 1'b1;
        #(Q / 2);
        chk("sda_driven_bit3", {31'h0, sda}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        chk("scoreboard_empty_rst", exp_q.size(), 32'h0);
        model_reset();
        #Q scl = 1'b0;
        #Q rst_n = 1'b1;
        i2c_stop();
        host_check(8'h12);
        wr_bytes = '{8'h5A};
        frame_write(8'h42, 8'h05);
        frame_read(8'h05, 1, 1'b0);
        host_check(8'h05);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
